branch_predict_unit: RTL and testbench

Parametrised successor to the EX-stage branch resolver. It adds a PC-indexed pattern history table (PHT) of saturating counters that supplies the IF-stage prediction. It resolves branches in EX against the prediction carried down the pipeline, and issues a same-cycle redirect/flush on a mispredict. It also keeps saturating branch and mispredict statistics, and runs a post-reset table-initialisation sweep.

---
 rtl/branch_predict_unit.sv | 135 +++++++++++++
 tb/tb_branch_predict_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// Branch predictor/resolver: PC-indexed PHT of saturating counters for IF prediction,
// EX-stage resolution with same-cycle redirect, saturating stats and a post-reset PHT sweep.
module branch_predict_unit #(
  parameter int unsigned DBITS          = 32,
  parameter int unsigned PHT_INDEX_BITS = 6,
  parameter int unsigned CNT_BITS       = 2,
  parameter int unsigned STAT_BITS      = 16,
  parameter logic [3:0]  BRANCH_OP      = 4'b0010
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DBITS-1:0]     IF_PC,
  output logic                 pred_taken,
  output logic                 busy,
  input  logic                 EX_valid,
  input  logic [3:0]           EX_opcode,
  input  logic [DBITS-1:0]     EX_PC,
  input  logic                 EX_condFlag,
  input  logic                 EX_pred,
  input  logic [DBITS-1:0]     EX_imm,
  output logic                 redirect,
  output logic [DBITS-1:0]     redirect_PC,
  output logic [1:0]           correct,
  output logic [STAT_BITS-1:0] br_count,
  output logic [STAT_BITS-1:0] mis_count
);

  localparam int unsigned PhtEntries = 2 ** PHT_INDEX_BITS;
  localparam logic [CNT_BITS-1:0] CntMax = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] WeakNt = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
  localparam logic [PHT_INDEX_BITS-1:0] LastIdx = {PHT_INDEX_BITS{1'b1}};

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e                    state_q, state_d;
  logic [PHT_INDEX_BITS-1:0] init_ptr_q, init_ptr_d;
  logic [STAT_BITS-1:0]      br_count_q, mis_count_q;
  logic [CNT_BITS-1:0]       pht [PhtEntries];

  logic [PHT_INDEX_BITS-1:0] if_idx, ex_idx, pht_waddr;
  logic [DBITS-1:0]          ex_br_pc, imm_shift;
  logic [CNT_BITS-1:0]       cnt_cur, cnt_next, pht_wdata;
  logic                      run, resolved, pht_we;

  // EX_PC points past the branch, so the branch's own PC is EX_PC - 4.
  assign ex_br_pc  = EX_PC - DBITS'(4);
  assign imm_shift = {EX_imm[DBITS-3:0], 2'b00};
  assign if_idx    = IF_PC[PHT_INDEX_BITS+1:2];
  assign ex_idx    = ex_br_pc[PHT_INDEX_BITS+1:2];
  assign run       = (state_q == StRun);
  assign resolved  = run && EX_valid && (EX_opcode == BRANCH_OP);
  assign cnt_cur   = pht[ex_idx];

  logic unused_bits;
  assign unused_bits = ^{ex_br_pc[DBITS-1:PHT_INDEX_BITS+2], ex_br_pc[1:0],
                         EX_imm[DBITS-1:DBITS-2]};

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    if (state_q == StInit) begin
      init_ptr_d = init_ptr_q + PHT_INDEX_BITS'(1);
      if (init_ptr_q == LastIdx) state_d = StRun;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StInit;
      init_ptr_q  <= '0;
      br_count_q  <= '0;
      mis_count_q <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      if (resolved && (br_count_q != '1)) br_count_q <= br_count_q + STAT_BITS'(1);
      if (redirect && (mis_count_q != '1)) mis_count_q <= mis_count_q + STAT_BITS'(1);
    end
  end

  always_comb begin
    cnt_next = cnt_cur;
    if (EX_condFlag) begin
      if (cnt_cur != CntMax) cnt_next = cnt_cur + CNT_BITS'(1);
    end else begin
      if (cnt_cur != '0) cnt_next = cnt_cur - CNT_BITS'(1);
    end
  end

  always_comb begin
    pht_we    = 1'b0;
    pht_waddr = ex_idx;
    pht_wdata = cnt_next;
    if (state_q == StInit) begin
      pht_we    = 1'b1;
      pht_waddr = init_ptr_q;
      pht_wdata = WeakNt;
    end else if (resolved) begin
      pht_we = 1'b1;
    end
  end

  // Table contents are don't-care until the sweep completes, so no reset here.
  always_ff @(posedge clk) begin
    if (pht_we) pht[pht_waddr] <= pht_wdata;
  end

  always_comb begin
    pred_taken  = 1'b0;
    busy        = (state_q == StInit);
    redirect    = 1'b0;
    correct     = 2'b11;
    redirect_PC = IF_PC + DBITS'(4);
    if (run) begin
      pred_taken = pht[if_idx][CNT_BITS-1];
      if (resolved) begin
        if (EX_condFlag == EX_pred) begin
          correct = 2'b10;
        end else if (EX_pred) begin
          correct     = 2'b00;
          redirect    = 1'b1;
          redirect_PC = EX_PC;
        end else begin
          correct     = 2'b01;
          redirect    = 1'b1;
          redirect_PC = EX_PC + imm_shift;
        end
      end
    end
  end

  assign br_count  = br_count_q;
  assign mis_count = mis_count_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: init sweep, resolution, PHT updates,
// read-during-write, stat saturation and mid-stream reset.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IF_PC;
  logic        pred_taken, busy;
  logic        EX_valid;
  logic [3:0]  EX_opcode;
  logic [31:0] EX_PC;
  logic        EX_condFlag, EX_pred;
  logic [31:0] EX_imm;
  logic        redirect;
  logic [31:0] redirect_PC;
  logic [1:0]  correct;
  logic [15:0] br_count, mis_count;

  int n_assert = 0;
  int n_fail   = 0;

  branch_predict_unit dut (
    .clk(clk), .reset(reset), .IF_PC(IF_PC), .pred_taken(pred_taken), .busy(busy),
    .EX_valid(EX_valid), .EX_opcode(EX_opcode), .EX_PC(EX_PC), .EX_condFlag(EX_condFlag),
    .EX_pred(EX_pred), .EX_imm(EX_imm), .redirect(redirect), .redirect_PC(redirect_PC),
    .correct(correct), .br_count(br_count), .mis_count(mis_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then settle inputs away from the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic ex_drive(input logic v, input logic [31:0] pc, input logic cond,
                          input logic pred, input logic [31:0] imm);
    EX_valid    = v;
    EX_opcode   = 4'b0010;
    EX_PC       = pc;
    EX_condFlag = cond;
    EX_pred     = pred;
    EX_imm      = imm;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    IF_PC = 32'h100;
    ex_drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1);
    check("rst_pred", pred_taken, 0);
    check("rst_br", br_count, 0);
    check("rst_mis", mis_count, 0);
    check("rst_correct", correct, 2'b11);
    #1 reset = 1'b0;
    #1;

    // Init sweep: 64 busy cycles, EX branch in the 10th is ignored.
    for (int i = 0; i < 64; i++) begin
      if (i == 9) begin
        ex_drive(1'b1, 32'h104, 1'b1, 1'b0, 32'hFFFF_FFFC);
        check("init_redirect", redirect, 0);
        check("init_correct", correct, 2'b11);
      end
      check("init_busy", busy, 1);
      check("init_pred", pred_taken, 0);
      step();
      ex_drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    end
    check("run_busy", busy, 0);
    check("run_br_zero", br_count, 0);
    check("run_pred_100", pred_taken, 0);
    IF_PC = 32'h0;  #1 check("run_pred_0", pred_taken, 0);
    IF_PC = 32'hFC; #1 check("run_pred_fc", pred_taken, 0);

    // Mispredict not-taken -> taken at PC 0x100, backward offset.
    IF_PC = 32'h50;
    ex_drive(1'b1, 32'h104, 1'b1, 1'b0, 32'hFFFF_FFFC);
    check("mp01_redirect", redirect, 1);
    check("mp01_correct", correct, 2'b01);
    check("mp01_pc", redirect_PC, 32'h0F4);
    step();
    ex_drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    IF_PC = 32'h100; #1;
    check("mp01_mis", mis_count, 1);
    check("mp01_br", br_count, 1);
    check("mp01_pred_after", pred_taken, 1);
    check("idle_correct", correct, 2'b11);
    check("idle_redirect", redirect, 0);
    check("idle_pc", redirect_PC, 32'h104);

    // Three more taken, predicted correctly: counter saturates at 11.
    IF_PC = 32'h50;
    for (int i = 0; i < 3; i++) begin
      ex_drive(1'b1, 32'h104, 1'b1, 1'b1, 32'hFFFF_FFFC);
      check("ok_correct", correct, 2'b10);
      check("ok_redirect", redirect, 0);
      check("ok_pc", redirect_PC, 32'h54);
      step();
    end
    ex_drive(1'b1, 32'h104, 1'b0, 1'b1, 32'hFFFF_FFFC);
    check("mp00_redirect", redirect, 1);
    check("mp00_correct", correct, 2'b00);
    check("mp00_pc", redirect_PC, 32'h104);
    step();
    ex_drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    IF_PC = 32'h100; #1;
    check("mp00_pred_after", pred_taken, 1);
    check("mp00_br", br_count, 5);
    check("mp00_mis", mis_count, 2);

    // Read-during-write on entry of PC 0x40 (01 -> 10).
    IF_PC = 32'h40;
    ex_drive(1'b1, 32'h44, 1'b1, 1'b0, 32'h8);
    check("rdw_pred_same", pred_taken, 0);
    check("rdw_pc", redirect_PC, 32'h64);
    step();
    ex_drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("rdw_pred_next", pred_taken, 1);

    // Non-branch opcode and bubble do nothing.
    ex_drive(1'b1, 32'h44, 1'b1, 1'b0, 32'h8);
    EX_opcode = 4'b0011; #1;
    check("nonbr_correct", correct, 2'b11);
    check("nonbr_redirect", redirect, 0);
    step();
    ex_drive(1'b0, 32'h44, 1'b1, 1'b0, 32'h8);
    check("bubble_correct", correct, 2'b11);
    step();
    check("nonbr_br", br_count, 6);
    check("nonbr_mis", mis_count, 3);

    // Down-saturation at PC 0x14: 01 -> 00 -> 00, then taken -> 01.
    IF_PC = 32'h14;
    for (int i = 0; i < 2; i++) begin
      ex_drive(1'b1, 32'h18, 1'b0, 1'b0, 32'h0);
      step();
    end
    ex_drive(1'b1, 32'h18, 1'b1, 1'b0, 32'h0);
    step();
    ex_drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("dnsat_pred", pred_taken, 0);
    check("dnsat_br", br_count, 9);
    check("dnsat_mis", mis_count, 4);

    // Drive br_count to saturation with correctly predicted branches.
    IF_PC = 32'h50;
    ex_drive(1'b1, 32'h104, 1'b1, 1'b1, 32'h0);
    repeat (65535 - 9) @(posedge clk);
    #2;
    check("sat_br_full", br_count, 16'hFFFF);
    step();
    check("sat_br_hold", br_count, 16'hFFFF);
    check("sat_mis", mis_count, 4);

    // Mid-stream reset with a branch still presented.
    reset = 1'b1;
    #1;
    check("mrst_br", br_count, 0);
    check("mrst_mis", mis_count, 0);
    check("mrst_busy", busy, 1);
    check("mrst_redirect", redirect, 0);
    check("mrst_correct", correct, 2'b11);
    check("mrst_pred", pred_taken, 0);
    step();
    reset = 1'b0;
    ex_drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    check("mrst_busy_after", busy, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
